// File: rtl/resp_demux_1_2.sv
`default_nettype none
// ============================================================================
// Module      : resp_demux_1_2
// Description : Steers an in-order response stream to consumer A or B using
//               destination bits queued in a route FIFO when the requests
//               were issued. One registered output stage decouples the
//               input from the consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_demux_1_2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tag_valid,
    input  logic                       tag_sel,
    output logic                       tag_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       a_valid,
    output logic [WIDTH-1:0]           a_data,
    input  logic                       a_ready,
    output logic                       b_valid,
    output logic [WIDTH-1:0]           b_data,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       err_unexpected
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Route FIFO state
    logic [DEPTH-1:0] r_route;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Output stage state
    logic             r_out_valid;
    logic             r_out_sel;
    logic [WIDTH-1:0] r_out_data;
    logic             r_err;

    // Handshake terms
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drain;
    logic w_accept;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = tag_valid & ~w_full;
    // A full FIFO refuses pushes even if a pop happens in the same cycle.
    assign tag_ready = ~w_full;

    assign w_drain  = r_out_valid & (r_out_sel ? b_ready : a_ready);
    // Only routes already stored may steer a response; a tag pushed this
    // cycle is not visible to the input until the next cycle.
    assign in_ready = ~w_empty & (~r_out_valid | w_drain);
    assign w_accept = in_valid & in_ready;

    assign a_valid        = r_out_valid & ~r_out_sel;
    assign b_valid        = r_out_valid &  r_out_sel;
    assign a_data         = r_out_data;
    assign b_data         = r_out_data;
    assign pending        = r_count;
    assign err_unexpected = r_err;

    // Route FIFO: store destination bits, advance pointers, track occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_route <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_route[r_wptr] <= tag_sel;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_accept) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_accept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load on accept, clear when drained with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= r_route[r_rptr];
            r_out_data  <= in_data;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flag for a response arriving with no route outstanding or in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (in_valid & w_empty & ~tag_valid) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_resp_demux_1_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_demux_1_2
// Description : Directed self-checking bench for resp_demux_1_2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_demux_1_2;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             tag_valid;
    logic             tag_sel;
    logic             tag_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic [2:0]       pending;
    logic             err_unexpected;

    int vectors;
    int miscompares;

    resp_demux_1_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tag_valid      (tag_valid),
        .tag_sel        (tag_sel),
        .tag_ready      (tag_ready),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .a_valid        (a_valid),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .pending        (pending),
        .err_unexpected (err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] sdata [4];
        logic        ssel  [4];
        logic        tagq  [$];
        logic [31:0] qa    [$];
        logic [31:0] qb    [$];
        int          tags_acc;
        int          resp_sent;
        int          delivered;
        logic        tf, inf, af, bf;
        logic [31:0] e;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; tag_valid = 1'b0; tag_sel = 1'b0;
        in_valid = 1'b0; in_data = '0; a_ready = 1'b1; b_ready = 1'b1;

        // ---- reset state
        #12;
        check("rst_tag_ready", tag_ready, 1);
        check("rst_pending",   pending, 0);
        check("rst_a_valid",   a_valid, 0);
        check("rst_b_valid",   b_valid, 0);
        check("rst_in_ready",  in_ready, 0);
        check("rst_err",       err_unexpected, 0);
        check("rst_a_data",    a_data, 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_pending", pending, 0);
        check("idle_tag_ready", tag_ready, 1);

        // ---- fill route FIFO with 0,1,1,0
        sdata = '{32'h11, 32'h22, 32'h33, 32'h44};
        ssel  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tag_valid = 1'b1; tag_sel = ssel[i];
            step();
        end
        tag_valid = 1'b0;
        #1;
        check("full_pending", pending, 4);
        check("full_tag_ready", tag_ready, 0);
        // push attempt while full is refused
        tag_valid = 1'b1; tag_sel = 1'b1;
        step();
        tag_valid = 1'b0;
        check("full_no_push", pending, 4);

        // ---- stream four responses at full rate
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = sdata[i];
            #1;
            check("stream_in_ready", in_ready, 1);
            step();
            check("stream_a_valid", a_valid, {63'd0, ~ssel[i]});
            check("stream_b_valid", b_valid, {63'd0, ssel[i]});
            check("stream_data", ssel[i] ? b_data : a_data, sdata[i]);
            check("stream_pending", pending, 3 - i);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_a", a_valid, 0);
        check("stream_end_b", b_valid, 0);

        // ---- consumer B stall
        tag_valid = 1'b1; tag_sel = 1'b1;
        step();
        tag_valid = 1'b0;
        b_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5A;
        #1;
        check("stall_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_b_valid", b_valid, 1);
            check("stall_b_data", b_data, 32'h5A);
            check("stall_a_valid", a_valid, 0);
            step();
        end
        tag_valid = 1'b1; tag_sel = 1'b0;
        step();
        tag_valid = 1'b0;
        in_valid = 1'b1; in_data = 32'h66;
        #1;
        check("stall2_in_ready", in_ready, 0);
        step();
        check("stall2_hold_b", b_data, 32'h5A);
        check("stall2_hold_bv", b_valid, 1);
        b_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("release_a_valid", a_valid, 1);
        check("release_a_data", a_data, 32'h66);
        check("release_b_valid", b_valid, 0);
        step();
        check("release_drained", a_valid, 0);

        // ---- same-cycle tag push and response with empty FIFO
        tag_valid = 1'b1; tag_sel = 1'b0;
        in_valid = 1'b1; in_data = 32'hAB;
        #1;
        check("same_in_ready", in_ready, 0);
        step();
        tag_valid = 1'b0;
        check("same_err", err_unexpected, 0);
        check("same_a_valid", a_valid, 0);
        check("same_pending", pending, 1);
        #1;
        check("same_next_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("same_a_valid2", a_valid, 1);
        check("same_a_data", a_data, 32'hAB);
        check("same_err2", err_unexpected, 0);
        step();

        // ---- unexpected response
        in_valid = 1'b1; in_data = 32'h77;
        #1;
        check("unexp_in_ready", in_ready, 0);
        step();
        check("unexp_err", err_unexpected, 1);
        check("unexp_a_valid", a_valid, 0);
        check("unexp_b_valid", b_valid, 0);
        in_valid = 1'b0;
        step();
        check("unexp_sticky", err_unexpected, 1);

        // ---- random tags and back-pressure, per-port order scoreboard
        tags_acc = 0; resp_sent = 0; delivered = 0;
        for (int cyc = 0; cyc < 600 && delivered < 20; cyc++) begin
            tag_valid = (tags_acc < 20) && ($urandom_range(0, 1) == 1);
            tag_sel   = 1'($urandom_range(0, 1));
            in_valid  = (resp_sent < tags_acc) && ($urandom_range(0, 2) != 0);
            in_data   = 32'h100 + 32'(resp_sent);
            a_ready   = ($urandom_range(0, 2) != 0);
            b_ready   = ($urandom_range(0, 2) != 0);
            #1;
            tf  = tag_valid & tag_ready;
            inf = in_valid & in_ready;
            af  = a_valid & a_ready;
            bf  = b_valid & b_ready;
            check("rand_pending_max", {63'd0, pending <= 3'd4}, 1);
            check("rand_pending", pending, 64'(tags_acc - resp_sent));
            if (af) begin
                e = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
                check("rand_a_data", a_data, e);
                delivered++;
            end
            if (bf) begin
                e = (qb.size() > 0) ? qb.pop_front() : 32'hDEAD_BEEF;
                check("rand_b_data", b_data, e);
                delivered++;
            end
            if (inf) begin
                if (tagq.size() > 0 && tagq.pop_front() == 1'b1) qb.push_back(in_data);
                else                                            qa.push_back(in_data);
                resp_sent++;
            end
            if (tf) begin
                tagq.push_back(tag_sel);
                tags_acc++;
            end
            step();
        end
        tag_valid = 1'b0; in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        check("rand_delivered", delivered, 20);
        step();
        check("rand_end_pending", pending, 0);

        // ---- asynchronous reset mid-transfer
        for (int i = 0; i < 4; i++) begin
            tag_valid = 1'b1; tag_sel = 1'b0;
            step();
        end
        tag_valid = 1'b0;
        a_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h99;
        step();
        in_valid = 1'b0;
        check("pre_rst_pending", pending, 3);
        check("pre_rst_a_valid", a_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_a_valid", a_valid, 0);
        check("arst_pending", pending, 0);
        check("arst_tag_ready", tag_ready, 1);
        check("arst_err", err_unexpected, 0);
        check("arst_a_data", a_data, 0);
        check("arst_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resp_demux_1_2.md
# resp_demux_1_2

Routes a single in-order response stream (WIDTH-bit valid/ready) to one of two consumers, A or B. Each response is steered by a destination bit that was recorded when the matching request was issued. It sits between the shared memory-response path and the fetch/load-store datapaths of the RISC-V core and performs the inverse of the 2:1 source select. A DEPTH-entry route FIFO holds the outstanding destination bits. A one-entry registered output stage decouples the input from the consumers.

## Interface
- WIDTH, 32, data width of responses
- DEPTH, 4, route FIFO entries; power of two, >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- tag_valid  input  1  request issued; push tag_sel into route FIFO
- tag_sel  input  1  destination of that request: 0 -> A, 1 -> B
- tag_ready  output  1  route FIFO not full
- in_valid  input  1  response present
- in_data  input  WIDTH  response data
- in_ready  output  1  response accepted this cycle when in_valid & in_ready
- a_valid  output  1  registered response for A
- a_data  output  WIDTH  response data for A
- a_ready  input  1  A accepts
- b_valid  output  1  registered response for B
- b_data  output  WIDTH  response data for B
- b_ready  input  1  B accepts
- pending  output  $clog2(DEPTH)+1  route FIFO occupancy
- err_unexpected  output  1  sticky: response arrived with no outstanding route

## Operation
- Route FIFO: write pointer, read pointer, and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push on tag_valid & tag_ready. tag_ready = (count != DEPTH). When full there is no bypass, even if a pop occurs in the same cycle.
- Output stage registers: out_valid, out_sel, out_data.
  - a_valid = out_valid & ~out_sel; b_valid = out_valid & out_sel.
  - a_data = b_data = out_data. The inactive port's data is don't-care.
- drain = out_valid & (out_sel ? b_ready : a_ready).
- in_ready = (count != 0) & (~out_valid | drain). The route head is evaluated from registered state only; a tag pushed this cycle cannot route a response in the same cycle.
- Accept (in_valid & in_ready):
  - out_data <= in_data, out_sel <= FIFO head, out_valid <= 1.
  - Pop the FIFO.
- Drain without accept: out_valid <= 0.
- Count update: +1 push only, -1 pop only, unchanged for push & pop or neither.
- err_unexpected is set when in_valid=1 & count=0 & tag_valid=0. It stays set until reset. The response is not consumed (in_ready=0).
- Consumer stall holds out_* stable; no loss or reordering.

## Timing
- Reset (rst_n low, asynchronous):
  - a_valid = b_valid = 0, a_data = b_data = 0.
  - in_ready = 0, tag_ready = 1, pending = 0, err_unexpected = 0.
  - FIFO pointers and output stage are cleared. Any held response and outstanding routes are discarded.
- Reset deassertion is synchronous to clk (handled externally). The first push is allowed on the first edge after release.
- Latency: response accepted at edge N appears on a_valid/b_valid after edge N, i.e. one cycle.
- Throughput: one response per cycle while the selected consumer keeps ready=1 and routes are available.
- Back-to-back responses to different ports: each is accepted only when the current output drains that cycle. There is no bubble.
- Push when count=DEPTH-1 with a simultaneous pop: accepted, count stays DEPTH-1.
- Tag push and response in the same cycle with count=0: response is not accepted, and err_unexpected is not set. The response is accepted next cycle.
- Pointer wrap after DEPTH pushes must preserve order.

## Test plan
- Reset then idle: tag_ready=1, pending=0, all valids 0. Assert rst_n low mid-transfer with pending=3 and a_valid=1: same-cycle a_valid=0, pending=0.
- Push tags 0,1,1,0 (DEPTH=4). Then tag_ready=0 and pending=4. Stream data 0x11,0x22,0x33,0x44 with a_ready=b_ready=1. A receives 0x11 then 0x44; B receives 0x22 then 0x33, one cycle after each accept.
- Push tag 1. Hold b_ready=0 and present 0x5A. Expect b_valid=1, b_data=0x5A, stable for 5 cycles. Present a second response with tag 0: in_ready=0 until b_ready=1, then A gets it on the next cycle.
- in_valid=1 with pending=0 and tag_valid=0: err_unexpected=1 and stays 1. in_ready=0 and no output valid.
- Same-cycle tag push (sel=0) and in_valid=0xAB with count=0: no accept that cycle and err stays 0. Accept next edge; a_data=0xAB one cycle later.
- 20 random tags with random a_ready/b_ready: per-port order matches tag order, pointers wrap, and pending never exceeds 4.
